// File: rtl/nn_pkg.sv
// Shared constants and types for the fully-connected classification stage.
package nn_pkg;

  localparam int unsigned NoOfKernels = 2;
  localparam int unsigned NoOfShapes  = 4;
  localparam int unsigned numAddr     = 5;
  localparam int unsigned ACC_W       = 20;

  typedef logic [3:0][7:0] pooled_t;
  typedef logic signed [ACC_W-1:0] score_t;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fc_state_t;

endpackage

// File: rtl/fc_dot.sv
// Combinational NK x 4 multiply-accumulate of unsigned pixels against signed weight bytes.
module fc_dot
  import nn_pkg::*;
#(
  parameter int unsigned NK   = NoOfKernels,
  parameter int unsigned AccW = ACC_W
) (
  input  pooled_t [NK-1:0]          pix_i,
  input  logic    [NK-1:0][31:0]    w_i,
  output logic signed [AccW-1:0]    score_o
);

  logic signed [AccW-1:0] acc;
  logic signed [16:0]     prod;

  always_comb begin
    acc  = '0;
    prod = '0;
    for (int k = 0; k < NK; k++) begin
      for (int i = 0; i < 4; i++) begin
        // Zero-extended pixel keeps the product signed without misreading pixels >= 128.
        prod = $signed({1'b0, pix_i[k][i]}) * $signed(w_i[k][8*i +: 8]);
        acc  = acc + AccW'(prod);
      end
    end
    score_o = acc;
  end

endmodule

// File: rtl/fc_classifier.sv
// Fully-connected classifier: streams one weight word per shape, scores it and keeps the arg-max.
module fc_classifier
  import nn_pkg::*;
#(
  parameter int unsigned NK    = NoOfKernels,
  parameter int unsigned NS    = NoOfShapes,
  parameter int unsigned AW    = numAddr,
  parameter int unsigned ACC_W = nn_pkg::ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    learn,
  input  logic                    start,
  input  pooled_t [NK-1:0]        pooled,
  input  logic [NK-1:0][31:0]     w_data,
  output logic [AW-1:0]           w_addr,
  output logic                    w_csb,
  output logic                    w_oeb,
  output logic                    w_web,
  output logic                    busy,
  output logic [7:0]              result,
  output logic                    result_valid,
  output logic signed [ACC_W-1:0] max_score
);

  fc_state_t               state_q, state_d;
  logic [AW-1:0]           s_q, s_d;
  pooled_t [NK-1:0]        pix_q, pix_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [AW-1:0]           rd_idx_q, rd_idx_d;
  logic signed [ACC_W-1:0] best_score_q, best_score_d;
  logic [AW-1:0]           best_idx_q, best_idx_d;
  logic [7:0]              result_q, result_d;
  logic signed [ACC_W-1:0] max_score_q, max_score_d;
  logic                    result_valid_q, result_valid_d;
  logic                    busy_q, busy_d;
  logic signed [ACC_W-1:0] score;

  fc_dot #(
    .NK   (NK),
    .AccW (ACC_W)
  ) u_fc_dot (
    .pix_i   (pix_q),
    .w_i     (w_data),
    .score_o (score)
  );

  always_comb begin
    state_d        = state_q;
    s_d            = s_q;
    pix_d          = pix_q;
    rd_valid_d     = 1'b0;
    rd_idx_d       = s_q;
    best_score_d   = best_score_q;
    best_idx_d     = best_idx_q;
    result_d       = result_q;
    max_score_d    = max_score_q;
    result_valid_d = 1'b0;
    busy_d         = busy_q;

    unique case (state_q)
      IDLE: begin
        if (start && !learn) begin
          pix_d   = pooled;
          s_d     = '0;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (learn) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          // Data for the address issued on this edge arrives next cycle.
          rd_valid_d = 1'b1;
          if (s_q == AW'(NS - 1)) begin
            state_d = DRAIN;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (learn) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        result_d       = 8'(best_idx_q);
        max_score_d    = best_score_q;
        result_valid_d = 1'b1;
        busy_d         = 1'b0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strict compare so ties keep the lowest shape index.
    if (rd_valid_q && ((rd_idx_q == '0) || (score > best_score_q))) begin
      best_score_d = score;
      best_idx_d   = rd_idx_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      s_q            <= '0;
      pix_q          <= '0;
      rd_valid_q     <= 1'b0;
      rd_idx_q       <= '0;
      best_score_q   <= '0;
      best_idx_q     <= '0;
      result_q       <= '0;
      max_score_q    <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      s_q            <= s_d;
      pix_q          <= pix_d;
      rd_valid_q     <= rd_valid_d;
      rd_idx_q       <= rd_idx_d;
      best_score_q   <= best_score_d;
      best_idx_q     <= best_idx_d;
      result_q       <= result_d;
      max_score_q    <= max_score_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  always_comb begin
    w_addr = (state_q == FETCH) ? s_q : '0;
    w_csb  = (state_q != FETCH);
    w_oeb  = (state_q != FETCH);
  end

  assign w_web        = 1'b1;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign max_score    = max_score_q;

endmodule

// File: tb/tb_fc_classifier.sv
// Scoreboard bench for fc_classifier: directed and random runs against an arithmetic reference.
module tb_fc_classifier;

  localparam int NK  = 2;
  localparam int NS  = 4;
  localparam int AW  = 5;
  localparam int AccW = 20;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   learn;
  logic                   start;
  logic [NK-1:0][3:0][7:0] pooled;
  logic [NK-1:0][31:0]    w_data;
  logic [AW-1:0]          w_addr;
  logic                   w_csb;
  logic                   w_oeb;
  logic                   w_web;
  logic                   busy;
  logic [7:0]             result;
  logic                   result_valid;
  logic signed [AccW-1:0] max_score;

  fc_classifier #(
    .NK    (NK),
    .NS    (NS),
    .AW    (AW),
    .ACC_W (AccW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .learn        (learn),
    .start        (start),
    .pooled       (pooled),
    .w_data       (w_data),
    .w_addr       (w_addr),
    .w_csb        (w_csb),
    .w_oeb        (w_oeb),
    .w_web        (w_web),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .max_score    (max_score)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [NK][32];

  // Synchronous-read weight memories.
  always @(posedge clk) begin
    if (!w_csb && !w_oeb) begin
      for (int k = 0; k < NK; k++) w_data[k] <= mem[k][w_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int idx;
    int score;
    int at;
  } exp_t;
  exp_t q[$];

  int last_res   = 0;
  int last_score = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_w_addr", w_addr, 0);
    chk("rst_w_csb", w_csb, 1);
    chk("rst_w_oeb", w_oeb, 1);
    chk("rst_w_web", w_web, 1);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_max_score", max_score, 0);
  endtask

  // Reference: score every shape with plain integer arithmetic, keep first strict maximum.
  function automatic void model(output int bi, output int bs);
    bi = 0;
    bs = 0;
    for (int s = 0; s < NS; s++) begin
      int sc = 0;
      for (int k = 0; k < NK; k++) begin
        for (int i = 0; i < 4; i++) begin
          logic [31:0] word;
          byte signed  wb;
          word = mem[k][s];
          wb   = word[8*i +: 8];
          sc   = sc + int'(pooled[k][i]) * int'(wb);
        end
      end
      if (s == 0 || sc > bs) begin
        bi = s;
        bs = sc;
      end
    end
  endfunction

  // Monitor: every result_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && result_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got result=%0d score=%0d, none expected", result,
                 max_score);
      end else begin
        e = q.pop_front();
        chk("result", result, e.idx);
        chk("max_score", max_score, e.score);
        chk("latency_cycle", cyc, e.at);
        chk("busy_at_valid", busy, 0);
        chk("w_csb_at_valid", w_csb, 1);
      end
    end
  end

  task automatic run(input bit use_model, input int xi, input int xs, input bit dbl,
                     input bit scramble);
    int bi, bs, n;
    if (use_model) model(bi, bs);
    else begin
      bi = xi;
      bs = xs;
    end
    @(negedge clk);
    start = 1'b1;
    // Start edge is the next posedge; valid is seen NS+2 edges after it.
    q.push_back('{idx: bi, score: bs, at: cyc + 1 + NS + 2});
    last_res   = bi;
    last_score = bs;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      for (int k = 0; k < NK; k++) pooled[k] = $urandom;
    end
    if (dbl) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL result_timeout: got no result_valid, required one within 20 cycles");
      q.delete();
    end
  endtask

  task automatic set_shape(input int s, input logic [31:0] word);
    for (int k = 0; k < NK; k++) mem[k][s] = word;
  endtask

  task automatic set_pix(input logic [7:0] v);
    for (int k = 0; k < NK; k++) pooled[k] = {4{v}};
  endtask

  initial begin
    rst    = 1'b1;
    learn  = 1'b0;
    start  = 1'b0;
    pooled = '0;
    for (int k = 0; k < NK; k++) begin
      for (int a = 0; a < 32; a++) mem[k][a] = '0;
    end
    #12;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;

    // 1: only shape 2 matches
    set_pix(8'd1);
    set_shape(2, 32'h0101_0101);
    run(0, 2, 8, 0, 0);

    // 2: all negative, least negative wins
    set_pix(8'd10);
    set_shape(0, 32'hFFFF_FFFF);
    set_shape(1, 32'hFEFE_FEFE);
    set_shape(2, 32'hFDFD_FDFD);
    set_shape(3, 32'hFCFC_FCFC);
    run(0, 0, -80, 0, 1);

    // 3: extremes
    set_pix(8'd255);
    for (int s = 0; s < NS; s++) set_shape(s, 32'h8080_8080);
    set_shape(3, 32'h7F7F_7F7F);
    run(0, 3, 259080, 0, 0);
    set_pix(8'd255);
    set_shape(3, 32'h8080_8080);
    run(0, 0, -261120, 0, 0);

    // 4: all-zero tie, with a second start while busy
    for (int s = 0; s < NS; s++) set_shape(s, 32'h0);
    set_pix(8'd7);
    run(0, 0, 0, 1, 0);

    // 5a: learn raised mid-run aborts without a result
    set_pix(8'd3);
    set_shape(1, 32'h0505_0505);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    learn = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_w_csb", w_csb, 1);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    learn = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_result_hold", result, last_res);
    chk("abort_score_hold", max_score, last_score);

    // 5b: start ignored while learning
    @(negedge clk);
    learn = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("learn_start_busy", busy, 0);
    chk("learn_start_csb", w_csb, 1);
    start = 1'b0;
    learn = 1'b0;
    repeat (8) @(negedge clk);

    // 6: asynchronous reset mid-FETCH
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals();
    #1 rst = 1'b0;
    last_res   = 0;
    last_score = 0;
    run(1, 0, 0, 0, 0);

    // Random runs
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < NK; k++) begin
        pooled[k] = $urandom;
        for (int s = 0; s < NS; s++) begin
          mem[k][s] = (r % 4 == 0) ? ($urandom & 32'h0303_0303) : $urandom;
        end
      end
      run(1, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
